// File: rtl/keypad_matrix_emu.sv
// Passive 4x4 keypad model: returns the active-low row code for one commanded key
// when its column is scanned, with contact bounce on press and release.
module keypad_matrix_emu #(
  parameter int HOLD_SCANS    = 4,
  parameter int BOUNCE_CYCLES = 6,
  parameter int BOUNCE_EDGES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] scan_code,
  input  logic [3:0] key_in,
  input  logic       start,
  output logic [3:0] read_code,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0]  LAST_CNT = 8'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] LAST_SEG = 16'(2 * BOUNCE_EDGES - 2);
  localparam logic [7:0]  HOLD_N   = 8'(HOLD_SCANS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [1:0]  row_q;
  logic [1:0]  col_q;
  logic        contact_q;
  logic [7:0]  seg_cnt_q;
  logic [15:0] seg_idx_q;
  logic [7:0]  scan_cnt_q;
  logic        prev_match_q;
  logic        busy_q;
  logic        done_q;

  logic        col_active;
  logic        seg_end;
  logic        last_seg;
  logic [15:0] seg_idx_d;

  assign col_active = ~scan_code[col_q];
  assign seg_end    = (seg_cnt_q == LAST_CNT);
  assign last_seg   = (seg_idx_q == LAST_SEG);
  assign seg_idx_d  = seg_idx_q + 16'd1;

  // Pure combinational path so the scanner sees the row in the same cycle it drives the column.
  assign read_code = (contact_q && col_active) ? ~(4'b0001 << row_q) : 4'b1111;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= 2'd0;
      col_q        <= 2'd0;
      contact_q    <= 1'b0;
      seg_cnt_q    <= 8'd0;
      seg_idx_q    <= 16'd0;
      scan_cnt_q   <= 8'd0;
      prev_match_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            row_q     <= key_in[3:2];
            col_q     <= key_in[1:0];
            contact_q <= 1'b1;
            busy_q    <= 1'b1;
            seg_cnt_q <= 8'd0;
            seg_idx_q <= 16'd0;
            state_q   <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (seg_end) begin
            seg_cnt_q <= 8'd0;
            if (last_seg) begin
              contact_q    <= 1'b1;
              scan_cnt_q   <= 8'd0;
              prev_match_q <= 1'b0;
              state_q      <= S_HOLD;
            end else begin
              seg_idx_q <= seg_idx_d;
              contact_q <= ~seg_idx_d[0];
            end
          end else begin
            seg_cnt_q <= seg_cnt_q + 8'd1;
          end
        end
        S_HOLD: begin
          prev_match_q <= col_active;
          if (scan_cnt_q != HOLD_N) begin
            if (col_active && !prev_match_q) begin
              scan_cnt_q <= scan_cnt_q + 8'd1;
            end
          end else if (!col_active) begin
            contact_q <= 1'b0;
            seg_cnt_q <= 8'd0;
            seg_idx_q <= 16'd0;
            state_q   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (seg_end) begin
            seg_cnt_q <= 8'd0;
            if (last_seg) begin
              contact_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              seg_idx_q <= seg_idx_d;
              contact_q <= seg_idx_d[0];
            end
          end else begin
            seg_cnt_q <= seg_cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Directed bench for keypad_matrix_emu at default parameters.
module tb_keypad_matrix_emu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] scan_code;
  logic [3:0] key_in;
  logic       start;
  logic [3:0] read_code;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  keypad_matrix_emu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_code (scan_code),
    .key_in    (key_in),
    .start     (start),
    .read_code (read_code),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] one_low(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return ~v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    scan_code = 4'b1110;
    key_in    = 4'd0;
    start     = 1'b0;
    tick(2);
    chk("rst_read", read_code, 4'b1111);
    chk("rst_busy", {3'b000, busy}, 4'b0000);
    chk("rst_done", {3'b000, done}, 4'b0000);

    rst_n = 1'b1;
    tick(1);

    // Key 6 press with column 2 held low throughout the bounce.
    key_in    = 4'd6;
    scan_code = 4'b1011;
    start     = 1'b1;
    tick(1);
    start  = 1'b0;
    key_in = 4'd0;
    chk("busy_rise", {3'b000, busy}, 4'b0001);
    for (int k = 0; k < 30; k++) begin
      chk("press_bounce", read_code, ((k / 6) % 2 == 0) ? 4'b1101 : 4'b1111);
      tick(1);
    end
    chk("hold_entry", read_code, 4'b1101);

    scan_code = 4'b0011;
    #1 chk("multi_col", read_code, 4'b1101);
    tick(1);
    scan_code = 4'b1111;
    #1 chk("no_col", read_code, 4'b1111);
    tick(1);
    for (int s = 0; s < 4; s++) begin
      scan_code = one_low(s);
      #1 chk("map_k6", read_code, (s == 2) ? 4'b1101 : 4'b1111);
      tick(1);
    end

    // Start/key during HOLD must be ignored.
    start  = 1'b1;
    key_in = 4'd5;
    tick(1);
    start = 1'b0;
    chk("busy_hold", {3'b000, busy}, 4'b0001);
    scan_code = 4'b1011;
    #1 chk("key_kept", read_code, 4'b1101);
    tick(1);
    scan_code = 4'b1110;
    tick(1);
    scan_code = 4'b1011;
    tick(1);
    tick(3);
    chk("wait_leave_busy", {3'b000, busy}, 4'b0001);
    chk("wait_leave_read", read_code, 4'b1101);
    scan_code = 4'b1110;
    #1 chk("leave_col", read_code, 4'b1111);
    tick(1);

    scan_code = 4'b1011;
    #1;
    for (int j = 0; j < 30; j++) begin
      chk("rel_bounce", read_code, ((j / 6) % 2 == 0) ? 4'b1111 : 4'b1101);
      chk("rel_nodone", {3'b000, done}, 4'b0000);
      tick(1);
    end
    chk("done_pulse", {3'b000, done}, 4'b0001);
    chk("busy_fall", {3'b000, busy}, 4'b0000);
    chk("done_read", read_code, 4'b1111);
    tick(1);
    chk("done_width", {3'b000, done}, 4'b0000);
    chk("fifth_scan", read_code, 4'b1111);

    // All 16 keys, back-to-back starts.
    for (int k = 0; k < 16; k++) begin
      key_in    = k[3:0];
      scan_code = 4'b1111;
      start     = 1'b1;
      tick(1);
      start = 1'b0;
      chk("key_busy", {3'b000, busy}, 4'b0001);
      tick(30);
      for (int sw = 0; sw < 4; sw++) begin
        for (int s = 0; s < 4; s++) begin
          scan_code = one_low(s);
          #1 chk("map_all", read_code, ((s == (k % 4)) && (sw < 3 || s <= (k % 4))) ?
                 one_low(k / 4) : 4'b1111);
          tick(1);
        end
      end
      scan_code = 4'b1111;
      for (int w = 0; w < 100 && done !== 1'b1; w++) tick(1);
      chk("done_seen", {3'b000, done}, 4'b0001);
      tick(1);
    end

    // Asynchronous reset in the middle of HOLD.
    key_in    = 4'd6;
    scan_code = 4'b1011;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    tick(30);
    chk("pre_reset_hold", read_code, 4'b1101);
    rst_n = 1'b0;
    #1 chk("async_rst_read", read_code, 4'b1111);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_busy", {3'b000, busy}, 4'b0000);
    chk("post_rst_done", {3'b000, done}, 4'b0000);
    chk("post_rst_read", read_code, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
